mul3_seq: RTL and testbench



---
 rtl/mul3_seq.sv | 133 +++++++++++++
 tb/tb_mul3_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mul3_seq.sv
// mul3_seq: sequential three-operand unsigned multiplier.
// Computes P1 = a*b and then P2 = P1*c with a radix-2 shift-add datapath,
// one multiplier bit per clock, full-width results with no truncation.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   a/b/c valid
//   in_ready   block idle and able to accept operands
//   a, b       WA-bit unsigned operands
//   c          WC-bit unsigned operand
//   out_valid  P1/P2 valid, held until out_ready is sampled high
//   out_ready  consumer accepts the result
//   P1         a*b,   2*WA bits, registered
//   P2         a*b*c, 2*WA+WC bits, registered
//
// state | meaning
// IDLE  | waiting for in_valid, in_ready high
// MUL1  | shift-add of a by b, one bit of b per edge
// MUL2  | shift-add of P1 by c, one bit of c per edge
// DONE  | result presented, waiting for out_ready
module mul3_seq #(
    parameter int WA = 4,
    parameter int WC = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WA-1:0]        a,
    input  logic [WA-1:0]        b,
    input  logic [WC-1:0]        c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WA-1:0]      P1,
    output logic [2*WA+WC-1:0]   P2
);

    localparam int WP1  = 2 * WA;
    localparam int WP2  = 2 * WA + WC;
    localparam int MAXW = (WA > WC) ? WA : WC;
    localparam int CW   = $clog2(MAXW);
    localparam logic [CW-1:0] LAST1 = CW'(WA - 1);
    localparam logic [CW-1:0] LAST2 = CW'(WC - 1);

    typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WP1-1:0]  acc1;
    logic [WP1-1:0]  mcand1;
    logic [WA-1:0]   mplier1;
    logic [WP2-1:0]  acc2;
    logic [WP2-1:0]  mcand2;
    logic [WC-1:0]   mplier2;
    logic [WP1-1:0]  sum1;
    logic [WP2-1:0]  sum2;

    // The multiplicand is pre-shifted and the multiplier shifted down each
    // edge, so bit 0 of the multiplier register is always multiplier bit cnt
    // and the added term is always operand << cnt.
    always_comb begin
        sum1 = acc1 + (mplier1[0] ? mcand1 : '0);
        sum2 = acc2 + (mplier2[0] ? mcand2 : '0);
    end

    assign in_ready = (state == IDLE) && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc1      <= '0;
            mcand1    <= '0;
            mplier1   <= '0;
            acc2      <= '0;
            mcand2    <= '0;
            mplier2   <= '0;
            out_valid <= 1'b0;
            P1        <= '0;
            P2        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand1  <= {{WA{1'b0}}, a};
                        mplier1 <= b;
                        mplier2 <= c;
                        acc1    <= '0;
                        acc2    <= '0;
                        cnt     <= '0;
                        state   <= MUL1;
                    end
                end
                MUL1: begin
                    if (cnt == LAST1) begin
                        P1     <= sum1;
                        mcand2 <= {{WC{1'b0}}, sum1};
                        acc1   <= '0;
                        cnt    <= '0;
                        state  <= MUL2;
                    end else begin
                        acc1    <= sum1;
                        mcand1  <= mcand1 << 1;
                        mplier1 <= mplier1 >> 1;
                        cnt     <= cnt + CW'(1);
                    end
                end
                MUL2: begin
                    if (cnt == LAST2) begin
                        P2        <= sum2;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        acc2    <= sum2;
                        mcand2  <= mcand2 << 1;
                        mplier2 <= mplier2 >> 1;
                        cnt     <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul3_seq.sv
// tb_mul3_seq: directed bench for mul3_seq at default widths (WA=4, WC=8)
// and at WA=8, WC=8, with hand-computed expected products and latencies.
module tb_mul3_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  a, b;
    logic [7:0]  c;
    logic [7:0]  P1;
    logic [15:0] P2;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, c8;
    logic [15:0] P1_8;
    logic [23:0] P2_8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul3_seq #(.WA(4), .WC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c),
        .out_valid(out_valid), .out_ready(out_ready),
        .P1(P1), .P2(P2)
    );

    mul3_seq #(.WA(8), .WC(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .c(c8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .P1(P1_8), .P2(P2_8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One default-width transaction; stall > 0 holds out_ready low for that
    // many cycles after out_valid while offering new operands that must be ignored.
    task automatic txn(input logic [31:0] ta, input logic [31:0] tb_, input logic [31:0] tc,
                       input logic [31:0] ep1, input logic [31:0] ep2, input int stall);
        int n;
        a = ta[3:0];
        b = tb_[3:0];
        c = tc[7:0];
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        check("in_ready_before_accept", in_ready, 1);
        tick();
        in_valid = 1'b0;
        a = 4'd0; b = 4'd0; c = 8'd0;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 4) check("p1_after_wa_edges", P1, ep1);
        end while (!out_valid && n < 60);
        check("latency", n, 12);
        check("p1", P1, ep1);
        check("p2", P2, ep2);
        if (stall > 0) begin
            in_valid = 1'b1;
            a = 4'd1; b = 4'd1; c = 8'd1;
            for (int i = 0; i < stall; i++) begin
                tick();
                check("stall_out_valid", out_valid, 1);
                check("stall_in_ready", in_ready, 0);
                check("stall_p1", P1, ep1);
                check("stall_p2", P2, ep2);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        check("out_valid_retired", out_valid, 0);
        check("in_ready_after", in_ready, 1);
        check("p1_held", P1, ep1);
        check("p2_held", P2, ep2);
    endtask

    initial begin
        int n;
        int seen;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        a8 = '0; b8 = '0; c8 = '0;

        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_p1", P1, 0);
        check("rst_p2", P2, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_in_ready8", in_ready8, 1);

        txn(3, 5, 7, 15, 105, 0);
        txn(15, 15, 255, 225, 57375, 0);
        txn(0, 9, 200, 0, 0, 0);
        txn(6, 7, 10, 42, 420, 5);

        // Abort in MUL2: accept edge, 4 MUL1 edges, then 2 into MUL2.
        a = 4'd9; b = 4'd9; c = 8'd9;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        check("mid_p1_before_reset", P1, 81);
        check("mid_in_ready", in_ready, 0);
        rst_n = 1'b0;
        tick();
        check("abort_out_valid", out_valid, 0);
        check("abort_p1", P1, 0);
        check("abort_p2", P2, 0);
        check("abort_in_ready", in_ready, 0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen = 1;
        end
        check("abort_no_pulse", seen, 0);
        check("abort_idle", in_ready, 1);
        txn(2, 2, 2, 4, 8, 0);

        // WA=8, WC=8: in_valid held high for two back-to-back transactions.
        a8 = 8'd200; b8 = 8'd3; c8 = 8'd100;
        in_valid8 = 1'b1;
        out_ready8 = 1'b1;
        check("w8_in_ready", in_ready8, 1);
        tick();
        a8 = 8'd255; b8 = 8'd255; c8 = 8'd255;
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid8 && n < 80);
        check("w8_latency", n, 16);
        check("w8_p1", P1_8, 600);
        check("w8_p2", P2_8, 60000);
        tick();
        check("w8_gap_out_valid", out_valid8, 0);
        check("w8_gap_in_ready", in_ready8, 1);
        tick();
        check("w8_reaccept_busy", in_ready8, 0);
        n = 2;
        do begin
            tick();
            n++;
        end while (!out_valid8 && n < 80);
        in_valid8 = 1'b0;
        check("w8_period", n, 18);
        check("w8_p1_max", P1_8, 65025);
        check("w8_p2_max", P2_8, 16581375);
        tick();
        check("w8_retired", out_valid8, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
